// File: rtl/serial_word_receiver.sv
// Deserializes a start/data/[parity]/stop framed serial stream into parallel words.
// Bit timing comes from an external sample strobe; status outputs are one-cycle registered pulses.
module serial_word_receiver #(
   parameter int WIDTH     = 4,
   parameter int PARITY_EN = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sample_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_error,
   output logic             parity_error,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0] bit_cnt_reg;
   logic             par_acc_reg;
   logic             par_pend_reg;
   logic             valid_next;
   logic             frame_err_next;
   logic             parity_err_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (sample_en) begin
         case (state_reg)
            IDLE: begin
               if (!serial_in) begin
                  state_next = DATA;
               end
            end
            DATA: begin
               if (bit_cnt_reg == LAST_BIT) begin
                  state_next = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Status decisions are all made on the stop sample; a pending parity error suppresses the load.
   always_comb begin
      valid_next      = 1'b0;
      frame_err_next  = 1'b0;
      parity_err_next = 1'b0;
      if (sample_en && (state_reg == STOP)) begin
         valid_next      = serial_in && !par_pend_reg;
         frame_err_next  = !serial_in;
         parity_err_next = par_pend_reg;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         par_acc_reg  <= 1'b0;
         par_pend_reg <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         frame_error  <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         data_valid   <= valid_next;
         frame_error  <= frame_err_next;
         parity_error <= parity_err_next;
         if (valid_next) begin
            data_out <= shift_reg;
         end
         if (sample_en) begin
            case (state_reg)
               IDLE: begin
                  if (!serial_in) begin
                     bit_cnt_reg  <= '0;
                     par_acc_reg  <= 1'b0;
                     par_pend_reg <= 1'b0;
                  end
               end
               DATA: begin
                  // Right shift so the first data bit lands in bit 0.
                  shift_reg   <= {serial_in, shift_reg[WIDTH-1:1]};
                  bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                  par_acc_reg <= par_acc_reg ^ serial_in;
               end
               PARITY: begin
                  par_pend_reg <= (serial_in != par_acc_reg);
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign busy = (state_reg != IDLE);

endmodule
